smart_toilet_pump_seq: RTL and testbench



---
 rtl/smart_toilet_pkg.sv | 39 +++
 rtl/smart_toilet_pump_seq_timer.sv | 29 ++
 rtl/smart_toilet_pump_seq.sv | 193 +++++++++++++++++++
 tb/tb_smart_toilet_pump_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/smart_toilet_pkg.sv
// rtl/smart_toilet_pkg.sv - shared phase codes, valve vector and widths for the pump sequencer
package smart_toilet_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int REP_W_DEF = 4;

  // Phase codes double as the externally visible phase output
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_INJ   = 3'd2;
  localparam logic [2:0] S_MIX   = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  typedef struct packed {
    logic soln1;
    logic soln2;
    logic soln3;
    logic flush;
  } valves_t;

  // soln3 feeds the serpentine delay chain, so it stays open through injection
  function automatic valves_t valve_decode(input logic [2:0] st);
    valves_t v;
    v = '0;
    case (st)
      S_PRIME: v.soln3 = 1'b1;
      S_INJ: begin
        v.soln1 = 1'b1;
        v.soln2 = 1'b1;
        v.soln3 = 1'b1;
      end
      S_FLUSH: v.flush = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/smart_toilet_pump_seq_timer.sv
// rtl/smart_toilet_pump_seq_timer.sv - shared phase down-counter with load and zero flag
module seq_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Load on phase entry, otherwise count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/smart_toilet_pump_seq.sv
// rtl/smart_toilet_pump_seq.sv - valve/pump sequencer for the smart-toilet fluidic assay chip
module smart_toilet_pump_seq
  import smart_toilet_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] prime_cyc,
  input  logic [CNT_W-1:0] inj_cyc,
  input  logic [CNT_W-1:0] mix_cyc,
  input  logic [CNT_W-1:0] flush_cyc,
  input  logic [REP_W-1:0] reps,
  output logic             v_soln1,
  output logic             v_soln2,
  output logic             v_soln3,
  output logic             v_flush,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [2:0]       phase,
  output logic [REP_W-1:0] rep_idx
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  logic [2:0]       state, state_nxt;
  logic [REP_W-1:0] rep_q, rep_nxt;
  logic             abf_q, abf_nxt;

  logic [CNT_W-1:0] sh_prime, sh_inj, sh_mix, sh_flush;
  logic [REP_W-1:0] sh_last;

  logic [CNT_W-1:0] d_prime, d_inj, d_mix, d_flush;
  logic [REP_W-1:0] d_last;
  logic             nz_p, nz_i, nz_m, nz_f;

  logic             accept;
  logic             adv, end_run;
  logic [2:0]       tgt;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic             tmr_zero;

  valves_t          valves_q;
  logic             busy_q, done_q, aborted_q;

  // First pass phase at or after 'from' with a nonzero duration; S_IDLE when none remain
  function automatic logic [2:0] first_nz(input logic [2:0] from, input logic p, input logic i,
                                          input logic m);
    logic [2:0] r;
    r = S_IDLE;
    if (from <= S_MIX && m) r = S_MIX;
    if (from <= S_INJ && i) r = S_INJ;
    if (from <= S_PRIME && p) r = S_PRIME;
    return r;
  endfunction

  assign accept = (state == S_IDLE) && start && !abort;

  // In IDLE the live inputs decide the first phase on the accepting edge
  assign d_prime = (state == S_IDLE) ? prime_cyc : sh_prime;
  assign d_inj   = (state == S_IDLE) ? inj_cyc   : sh_inj;
  assign d_mix   = (state == S_IDLE) ? mix_cyc   : sh_mix;
  assign d_flush = (state == S_IDLE) ? flush_cyc : sh_flush;
  assign d_last  = (state == S_IDLE) ? ((reps == '0) ? '0 : reps - REP_ONE) : sh_last;

  assign nz_p = (d_prime != '0);
  assign nz_i = (d_inj   != '0);
  assign nz_m = (d_mix   != '0);
  assign nz_f = (d_flush != '0);

  // Next-state: zero-length phases are skipped so the chain resolves within one edge
  always_comb begin
    state_nxt = state;
    rep_nxt   = rep_q;
    abf_nxt   = abf_q;
    adv       = 1'b0;
    end_run   = 1'b0;
    tgt       = S_IDLE;
    case (state)
      S_IDLE: begin
        if (accept) begin
          adv     = 1'b1;
          rep_nxt = '0;
          abf_nxt = 1'b0;
          tgt     = first_nz(S_PRIME, nz_p, nz_i, nz_m);
          end_run = (tgt == S_IDLE);
        end
      end
      S_PRIME, S_INJ, S_MIX: begin
        if (abort) begin
          adv     = 1'b1;
          abf_nxt = 1'b1;
          end_run = 1'b1;
        end else if (tmr_zero) begin
          adv = 1'b1;
          tgt = first_nz(state + 3'd1, nz_p, nz_i, nz_m);
          if (tgt == S_IDLE) begin
            if (rep_q < d_last) begin
              rep_nxt = rep_q + REP_ONE;
              tgt     = first_nz(S_PRIME, nz_p, nz_i, nz_m);
            end else begin
              end_run = 1'b1;
            end
          end
        end
      end
      S_FLUSH: begin
        if (tmr_zero) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (adv) state_nxt = end_run ? (nz_f ? S_FLUSH : S_DONE) : tgt;
  end

  // Timer is loaded with N-1 whenever a timed phase is entered
  always_comb begin
    load     = adv && (state_nxt != S_DONE);
    load_val = '0;
    case (state_nxt)
      S_PRIME: load_val = d_prime - CNT_ONE;
      S_INJ:   load_val = d_inj - CNT_ONE;
      S_MIX:   load_val = d_mix - CNT_ONE;
      S_FLUSH: load_val = d_flush - CNT_ONE;
      default: load_val = '0;
    endcase
  end

  seq_phase_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .zero    (tmr_zero)
  );

  // Shadow copies of the run parameters, captured only when a start is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_prime <= '0;
      sh_inj   <= '0;
      sh_mix   <= '0;
      sh_flush <= '0;
      sh_last  <= '0;
    end else if (accept) begin
      sh_prime <= prime_cyc;
      sh_inj   <= inj_cyc;
      sh_mix   <= mix_cyc;
      sh_flush <= flush_cyc;
      sh_last  <= d_last;
    end
  end

  // State and every output register move on the same edge, so valves never glitch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rep_q     <= '0;
      abf_q     <= 1'b0;
      valves_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      rep_q     <= rep_nxt;
      abf_q     <= abf_nxt;
      valves_q  <= valve_decode(state_nxt);
      busy_q    <= (state_nxt != S_IDLE);
      done_q    <= (state_nxt == S_DONE);
      aborted_q <= (state_nxt == S_DONE) && abf_nxt;
    end
  end

  assign v_soln1 = valves_q.soln1;
  assign v_soln2 = valves_q.soln2;
  assign v_soln3 = valves_q.soln3;
  assign v_flush = valves_q.flush;
  assign busy    = busy_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign phase   = state;
  assign rep_idx = rep_q;

endmodule

// File: tb/tb_smart_toilet_pump_seq.sv
// tb/tb_smart_toilet_pump_seq.sv - self-checking bench for the pump sequencer
module tb_smart_toilet_pump_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [15:0] prime_cyc, inj_cyc, mix_cyc, flush_cyc;
  logic [3:0]  reps;
  logic        v_soln1, v_soln2, v_soln3, v_flush;
  logic        busy, done, aborted;
  logic [2:0]  phase;
  logic [3:0]  rep_idx;

  typedef struct {
    int ph;
    int rep;
    bit ab;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   tb_done = 1'b0;

  smart_toilet_pump_seq #(.CNT_W(16), .REP_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .prime_cyc(prime_cyc), .inj_cyc(inj_cyc), .mix_cyc(mix_cyc), .flush_cyc(flush_cyc),
    .reps(reps),
    .v_soln1(v_soln1), .v_soln2(v_soln2), .v_soln3(v_soln3), .v_flush(v_flush),
    .busy(busy), .done(done), .aborted(aborted), .phase(phase), .rep_idx(rep_idx)
  );

  always #5 clk = ~clk;

  // {soln1, soln2, soln3, flush} expected for each phase
  function automatic logic [3:0] exp_valves(input int ph);
    case (ph)
      1: return 4'b0010;
      2: return 4'b1110;
      4: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  // Expand a run into its per-cycle phase schedule; returns cycles from first phase through DONE
  task automatic build(input int p, input int i, input int m, input int f, input int r,
                       input int ab_at, output int len);
    exp_t tr[$];
    int   eff;
    int   rp;
    bit   ab;
    eff = (r == 0) ? 1 : r;
    ab  = 1'b0;
    for (int k = 0; k < eff; k++) begin
      if (p + i + m == 0) break;
      for (int c = 0; c < p; c++) tr.push_back('{1, k, 1'b0});
      for (int c = 0; c < i; c++) tr.push_back('{2, k, 1'b0});
      for (int c = 0; c < m; c++) tr.push_back('{3, k, 1'b0});
    end
    if (ab_at > 0 && ab_at <= int'(tr.size())) begin
      ab = 1'b1;
      while (int'(tr.size()) > ab_at) void'(tr.pop_back());
    end
    rp = (tr.size() > 0) ? tr[tr.size()-1].rep : 0;
    for (int c = 0; c < f; c++) tr.push_back('{4, rp, 1'b0});
    tr.push_back('{5, rp, ab});
    len = int'(tr.size());
    exp_q.push_back('{0, 0, 1'b0});
    foreach (tr[n]) exp_q.push_back(tr[n]);
    exp_q.push_back('{0, 0, 1'b0});
  endtask

  task automatic drain(input string nm);
    for (int t = 0; t < 300 && exp_q.size() > 0; t++) @(posedge clk);
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: %0d expected cycles left, expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input string nm, input int p, input int i, input int m, input int f,
                     input int r, input int ab_at, input bit poke, input int exp_len);
    int len;
    @(posedge clk);
    #1;
    build(p, i, m, f, r, ab_at, len);
    chk({nm, "_len"}, len, exp_len);
    prime_cyc = 16'(p);
    inj_cyc   = 16'(i);
    mix_cyc   = 16'(m);
    flush_cyc = 16'(f);
    reps      = 4'(r);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    if (ab_at > 0) begin
      repeat (ab_at - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
    end
    if (poke) begin
      prime_cyc = 16'd9;
      inj_cyc   = 16'd1;
      mix_cyc   = 16'd7;
      flush_cyc = 16'd5;
      reps      = 4'd2;
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    drain(nm);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    prime_cyc = '0;
    inj_cyc = '0;
    mix_cyc = '0;
    flush_cyc = '0;
    reps = '0;
    fork
      begin
        int len;
        #2;
        chk("reset_outputs", int'({v_soln1, v_soln2, v_soln3, v_flush, busy, done, aborted,
                                   phase, rep_idx}), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        run("nominal",   4, 3, 5, 2, 1, 0, 1'b0, 15);
        run("repeats",   2, 2, 2, 1, 3, 0, 1'b0, 20);
        run("zero_skip", 0, 3, 0, 0, 1, 0, 1'b0, 4);
        run("abort_inj", 2, 4, 3, 3, 1, 4, 1'b0, 8);
        run("abort_nf",  3, 2, 2, 0, 1, 2, 1'b0, 3);
        run("abort_p2",  1, 1, 1, 2, 2, 5, 1'b0, 8);
        run("busy_poke", 4, 3, 5, 2, 1, 0, 1'b1, 15);
        run("all_zero",  0, 0, 0, 0, 2, 0, 1'b0, 1);

        // start and abort together in IDLE: abort wins
        @(posedge clk);
        #1;
        repeat (3) exp_q.push_back('{0, 0, 1'b0});
        prime_cyc = 16'd2;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        drain("start_abort");

        // asynchronous reset in the middle of MIX
        @(posedge clk);
        #1;
        build(4, 3, 5, 2, 1, 0, len);
        prime_cyc = 16'd4;
        inj_cyc = 16'd3;
        mix_cyc = 16'd5;
        flush_cyc = 16'd2;
        reps = 4'd1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        exp_q.delete();
        chk("mid_mix_phase", int'(phase), 3);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", int'({v_soln1, v_soln2, v_soln3, v_flush, busy, done,
                                         aborted, phase, rep_idx}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_idle", int'({busy, phase}), 0);

        run("reps_zero", 1, 1, 1, 1, 0, 0, 1'b0, 5);
        tb_done = 1'b1;
      end
      begin
        while (!tb_done) begin
          @(negedge clk);
          if (exp_q.size() > 0) begin
            exp_t       e;
            logic [3:0] ev, av;
            bit         ok;
            e  = exp_q.pop_front();
            ev = exp_valves(e.ph);
            av = {v_soln1, v_soln2, v_soln3, v_flush};
            ok = (phase == 3'(e.ph)) && (av == ev) && (busy == (e.ph != 0)) &&
                 (done == (e.ph == 5)) && (aborted == (e.ph == 5 && e.ab)) &&
                 (e.ph == 0 || rep_idx == 4'(e.rep));
            vectors++;
            if (!ok) begin
              miscompares++;
              $display("FAIL cycle t=%0t: phase=%0d valves=%b busy=%b done=%b aborted=%b rep=%0d, expected phase=%0d valves=%b busy=%b done=%b aborted=%b rep=%0d",
                       $time, phase, av, busy, done, aborted, rep_idx,
                       e.ph, ev, (e.ph != 0), (e.ph == 5), (e.ph == 5 && e.ab), e.rep);
            end
          end
        end
      end
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
